uart_rx_ctrl: RTL and testbench
===============================

# uart_rx_ctrl

Frame sequencer for the UART receive path. It sits between the oversampling data sampler and the start, parity and stop checkers plus the deserializer. It owns the edge and bit counters, enables each checker during its bit slot, and gives the start checker its low-level clear. It raises `data_valid` or `frame_err` once per received frame.

## Interface

Parameters:
- `PRESCALE_W`, default 6: width of `Prescale` and `edge_cnt`.
- `DATA_W`, default 8: data bits per frame.

Ports:
- `CLK`  in  1  system clock; all logic on the rising edge.
- `RST`  in  1  reset; synchronous, active-high.
- `RX_IN`  in  1  serial line, already synchronized; idle high.
- `PAR_EN`  in  1  frame carries a parity bit.
- `Prescale`  in  PRESCALE_W  oversampling ratio; legal values 8, 16, 32.
- `DONE`  in  1  one-cycle pulse from the sampler: sampled bit is valid.
- `strt_glitch`  in  1  start checker flag.
- `par_err`  in  1  parity checker flag.
- `stp_err`  in  1  stop checker flag.
- `dat_samp_en`  out  1  sampler enable.
- `edge_cnt`  out  PRESCALE_W  oversample edge index within the current bit.
- `bit_cnt`  out  4  bit index within the frame.
- `strt_chk_en`  out  1  start checker enable.
- `par_chk_en`  out  1  parity checker enable.
- `stp_chk_en`  out  1  stop checker enable.
- `clearFlag`  out  1  low-level clear to the start checker.
- `deser_en`  out  1  deserializer shift strobe.
- `data_valid`  out  1  one-cycle pulse: frame good.
- `frame_err`  out  1  one-cycle pulse: frame bad.

## Operation

- States: IDLE, START, DATA, PARITY, STOP, CHECK. All outputs are Moore outputs, decoded from registered state and counters.
- Bit indices: bit 0 is start; bits 1..DATA_W are data; bit DATA_W+1 is parity when enabled; the last bit is stop.
- `PAR_EN` and `Prescale` are latched on entry to START. Changes mid-frame are ignored.
- Edge counter:
  - Runs 0..P-1 in every state except IDLE, where P is the latched `Prescale`.
  - At P-1 it wraps to 0 and `bit_cnt` increments.
  - Both counters are held at 0 in IDLE.
- IDLE:
  - `RX_IN`=0 moves to START with `edge_cnt`=1; the detect cycle counts as edge 0 of the start bit.
- START:
  - At `edge_cnt`=P-1: `strt_glitch`=1 moves to IDLE; otherwise moves to DATA.
- DATA:
  - `deser_en` = `DONE` while in DATA.
  - At the end of bit DATA_W: moves to PARITY if parity is enabled, else to STOP.
- PARITY:
  - At the end of the bit, moves to STOP.
- STOP:
  - At the end of the bit, moves to CHECK.
- CHECK (one cycle):
  - Error condition is `stp_err` OR (latched `PAR_EN` AND `par_err`).
  - No error: `data_valid`=1. Error: `frame_err`=1.
  - Next state: `RX_IN`=0 moves to START with `edge_cnt`=1 (back-to-back frame); otherwise moves to IDLE.
- Enable decoding:
  - `dat_samp_en`=1 in every state except IDLE.
  - `strt_chk_en`=1 in START only.
  - `par_chk_en`=1 in PARITY only.
  - `stp_chk_en`=1 in STOP only.
  - `clearFlag`=0 in IDLE and CHECK, 1 elsewhere.
- `DONE` outside DATA has no effect on `deser_en`.
- Precedence: RST wins over every transition.

## Timing

- On any cycle with `RST`=1, the next state is IDLE. After that edge:
  - `edge_cnt`=0 and `bit_cnt`=0.
  - `clearFlag`=0.
  - Every other output is 0.
- Reset mid-frame aborts the frame with no `data_valid` and no `frame_err`.
- Frame length is N = (DATA_W + 2 + PAR_EN) × P cycles. Taking the detect cycle as cycle 0, CHECK occurs at cycle N.
  - Example: P=8, parity on gives N=88; parity off gives N=80.
- Glitch reject: IDLE is re-entered at cycle P after the detect cycle.
- Checker timing requirement: `DONE` and the checker flags must settle by `edge_cnt`=P-1 of their bit. The sampler guarantees this with `DONE` at or before edge P/2+2.

## Structure

- Shared package `uart_rx_pkg` holds:
  - the state encoding constants;
  - the bit-index constants (START_BIT=0, first data bit=1);
  - legal prescale values.
- One sub-module: `uart_edge_bit_counter`.
  - Inputs: enable, wrap value P, load-to-1 strobe.
  - Outputs: `edge_cnt`, `bit_cnt`.
  - `uart_rx_ctrl` instantiates it beside the FSM.

## Test plan

- Good frame, parity on: P=8, `PAR_EN`=1, data 0xA5 with even parity, sampler model drives `DONE` at edge 6 → 8 `deser_en` pulses; `data_valid`=1 at cycle 88; `frame_err` stays 0.
- Start glitch: P=8, `RX_IN` low for 2 cycles, `strt_glitch`=1 by edge 7 → IDLE at cycle 8; no `deser_en`; no `data_valid`; `clearFlag`=0 from cycle 8.
- Parity error: same frame as the first scenario with `par_err`=1 in PARITY → `frame_err`=1 at cycle 88; `data_valid`=0. With `PAR_EN`=0 and `par_err` forced to 1 → `data_valid`=1 at cycle 80.
- Back-to-back: P=16, parity off, second start bit immediately after the stop bit → CHECK goes straight to START; `data_valid` at cycles 160 and 320; no IDLE cycle between the frames.
- Reset mid-frame: `RST`=1 during DATA bit 4 → next cycle IDLE with all outputs at their reset values; a following clean frame is received correctly.
- Config change mid-frame: `PAR_EN` toggled 1→0 and `Prescale` changed 8→16 during DATA → frame completes with the latched values; CHECK at cycle 88.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared encodings for the UART receive frame sequencer: FSM states, frame bit
// indices and the oversampling ratios the sampler supports.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        CHECK  = 3'd5
    } rx_state_t;

    localparam int START_BIT      = 0;
    localparam int FIRST_DATA_BIT = 1;

    localparam int PRESCALE_8  = 8;
    localparam int PRESCALE_16 = 16;
    localparam int PRESCALE_32 = 32;

    function automatic logic prescale_legal(input int p);
        return (p == PRESCALE_8) || (p == PRESCALE_16) || (p == PRESCALE_32);
    endfunction

endpackage

// File: rtl/uart_edge_bit_counter.sv
// Oversample edge counter with bit counter: edge_cnt runs 0..wrap-1 and bumps
// bit_cnt on each wrap; cleared while disabled, preset to edge 1 on load_one.
module uart_edge_bit_counter
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  load_one,
    input  logic [PRESCALE_W-1:0] wrap,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [3:0]            bit_cnt
);

    logic last_edge;

    assign last_edge = (edge_cnt == (wrap - 1'b1));

    always_ff @(posedge clk) begin
        if (rst) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (load_one) begin
            // the start-detect cycle already counted as edge 0
            edge_cnt <= PRESCALE_W'(1);
            bit_cnt  <= 4'(START_BIT);
        end else if (!en) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (last_edge) begin
            edge_cnt <= '0;
            bit_cnt  <= bit_cnt + 4'd1;
        end else begin
            edge_cnt <= edge_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive frame sequencer: tracks start/data/parity/stop bit slots, gates
// the checkers and deserializer, and reports each frame as good or bad.
//
// state  | meaning
// IDLE   | line idle, waiting for a falling edge on RX_IN
// START  | start bit; start checker enabled, glitch returns to IDLE
// DATA   | data bits; each sampler DONE shifts the deserializer
// PARITY | parity bit (only when latched PAR_EN); parity checker enabled
// STOP   | stop bit; stop checker enabled
// CHECK  | one cycle verdict: data_valid or frame_err
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE_W = 6,
    parameter int DATA_W     = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic                  DONE,
    input  logic                  strt_glitch,
    input  logic                  par_err,
    input  logic                  stp_err,
    output logic                  dat_samp_en,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [3:0]            bit_cnt,
    output logic                  strt_chk_en,
    output logic                  par_chk_en,
    output logic                  stp_chk_en,
    output logic                  clearFlag,
    output logic                  deser_en,
    output logic                  data_valid,
    output logic                  frame_err
);

    localparam logic [3:0] LAST_DATA_BIT = 4'(FIRST_DATA_BIT + DATA_W - 1);

    rx_state_t             state, state_nxt;
    logic                  par_lat;
    logic [PRESCALE_W-1:0] p_lat;
    logic                  last_edge;
    logic                  frame_bad;
    logic                  load_one;
    logic                  cnt_en;

    uart_edge_bit_counter #(
        .PRESCALE_W (PRESCALE_W)
    ) u_edge_bit_counter (
        .clk      (CLK),
        .rst      (RST),
        .en       (cnt_en),
        .load_one (load_one),
        .wrap     (p_lat),
        .edge_cnt (edge_cnt),
        .bit_cnt  (bit_cnt)
    );

    assign last_edge = (edge_cnt == (p_lat - 1'b1));
    assign frame_bad = stp_err | (par_lat & par_err);
    assign cnt_en    = (state_nxt != IDLE);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Frame configuration is frozen at start-bit entry; an unsupported ratio
    // falls back to 8 so the edge counter always has a sane wrap point.
    always_ff @(posedge CLK) begin
        if (RST) begin
            par_lat <= 1'b0;
            p_lat   <= PRESCALE_W'(PRESCALE_8);
        end else if (load_one) begin
            par_lat <= PAR_EN;
            p_lat   <= prescale_legal(int'(Prescale)) ? Prescale
                                                      : PRESCALE_W'(PRESCALE_8);
        end
    end

    always_comb begin
        state_nxt   = state;
        load_one    = 1'b0;
        dat_samp_en = 1'b0;
        strt_chk_en = 1'b0;
        par_chk_en  = 1'b0;
        stp_chk_en  = 1'b0;
        clearFlag   = 1'b0;
        deser_en    = 1'b0;
        data_valid  = 1'b0;
        frame_err   = 1'b0;

        case (state)
            IDLE: begin
                if (!RX_IN) begin
                    state_nxt = START;
                    load_one  = 1'b1;
                end
            end
            START: begin
                dat_samp_en = 1'b1;
                strt_chk_en = 1'b1;
                clearFlag   = 1'b1;
                if (last_edge) begin
                    state_nxt = strt_glitch ? IDLE : DATA;
                end
            end
            DATA: begin
                dat_samp_en = 1'b1;
                clearFlag   = 1'b1;
                deser_en    = DONE;
                if (last_edge && (bit_cnt == LAST_DATA_BIT)) begin
                    state_nxt = par_lat ? PARITY : STOP;
                end
            end
            PARITY: begin
                dat_samp_en = 1'b1;
                par_chk_en  = 1'b1;
                clearFlag   = 1'b1;
                if (last_edge) begin
                    state_nxt = STOP;
                end
            end
            STOP: begin
                dat_samp_en = 1'b1;
                stp_chk_en  = 1'b1;
                clearFlag   = 1'b1;
                if (last_edge) begin
                    state_nxt = CHECK;
                end
            end
            CHECK: begin
                dat_samp_en = 1'b1;
                data_valid  = !frame_bad;
                frame_err   = frame_bad;
                // a low line here is already the next start bit's edge 0
                if (!RX_IN) begin
                    state_nxt = START;
                    load_one  = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: drives whole frames cycle by cycle from the
// detect cycle and checks counters, enables and verdict timing.
module tb_uart_rx_ctrl;

    localparam int PW = 6;
    localparam int DW = 8;

    logic          CLK = 1'b0;
    logic          RST;
    logic          RX_IN;
    logic          PAR_EN;
    logic [PW-1:0] Prescale;
    logic          DONE;
    logic          strt_glitch;
    logic          par_err;
    logic          stp_err;
    logic          dat_samp_en;
    logic [PW-1:0] edge_cnt;
    logic [3:0]    bit_cnt;
    logic          strt_chk_en;
    logic          par_chk_en;
    logic          stp_chk_en;
    logic          clearFlag;
    logic          deser_en;
    logic          data_valid;
    logic          frame_err;

    uart_rx_ctrl #(
        .PRESCALE_W (PW),
        .DATA_W     (DW)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .RX_IN       (RX_IN),
        .PAR_EN      (PAR_EN),
        .Prescale    (Prescale),
        .DONE        (DONE),
        .strt_glitch (strt_glitch),
        .par_err     (par_err),
        .stp_err     (stp_err),
        .dat_samp_en (dat_samp_en),
        .edge_cnt    (edge_cnt),
        .bit_cnt     (bit_cnt),
        .strt_chk_en (strt_chk_en),
        .par_chk_en  (par_chk_en),
        .stp_chk_en  (stp_chk_en),
        .clearFlag   (clearFlag),
        .deser_en    (deser_en),
        .data_valid  (data_valid),
        .frame_err   (frame_err)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_mis = 0;

    int         r_deser, r_dv_cnt, r_dv_first, r_dv_last;
    int         r_fe_cnt, r_fe_first, r_ctr_bad, r_en_bad;
    logic [7:0] r_byte;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One or more back-to-back frames starting at cycle 0 (the detect cycle).
    // Sampler DONE lands on edge p/2+2 of every bit; checker flags are held
    // constant through the frame. chg_k / rst_k < 0 disable those events.
    task automatic run_seq(input int p, input bit pen, input logic [7:0] data,
                           input bit perr, input bit serr, input int nfr,
                           input int chg_k, input int rst_k);
        int         n, ncyc, fk, b, stop_b, exp_edge, exp_bit;
        bit         after_rst;
        logic       lb;
        logic [4:0] exp_en, got_en;
        n      = (DW + 2 + (pen ? 1 : 0)) * p;
        stop_b = DW + 1 + (pen ? 1 : 0);
        ncyc   = nfr * n + 4;
        r_deser = 0; r_dv_cnt = 0; r_dv_first = -1; r_dv_last = -1;
        r_fe_cnt = 0; r_fe_first = -1; r_ctr_bad = 0; r_en_bad = 0;
        r_byte = 8'h00;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge CLK);
            after_rst = (rst_k >= 0) && (k > rst_k);
            fk = k % n;
            b  = fk / p;
            if (k == 0) begin
                PAR_EN   = pen;
                Prescale = PW'(p);
            end
            if (k == chg_k) begin
                PAR_EN   = 1'b0;
                Prescale = 6'd16;
            end
            RST = (k == rst_k);
            if (after_rst || k >= nfr * n) lb = 1'b1;
            else if (b == 0)               lb = 1'b0;
            else if (b <= DW)              lb = data[b-1];
            else if (pen && b == DW + 1)   lb = ^data;
            else                           lb = 1'b1;
            RX_IN   = lb;
            DONE    = !after_rst && (k < nfr * n) && ((fk % p) == (p / 2 + 2));
            par_err = !after_rst && (k <= nfr * n) && perr;
            stp_err = !after_rst && (k <= nfr * n) && serr;
            #1;
            if (deser_en) begin
                r_deser++;
                r_byte = {RX_IN, r_byte[7:1]};
            end
            if (data_valid) begin
                r_dv_cnt++;
                if (r_dv_first < 0) r_dv_first = k;
                r_dv_last = k;
            end
            if (frame_err) begin
                r_fe_cnt++;
                if (r_fe_first < 0) r_fe_first = k;
            end
            if (rst_k >= 0 && k == rst_k + 1)
                chk("rst_mid_outputs",
                    {edge_cnt, bit_cnt, dat_samp_en, strt_chk_en, par_chk_en,
                     stp_chk_en, clearFlag, deser_en, data_valid, frame_err}, 0);
            if (!after_rst && k <= nfr * n + 1) begin
                if (k == 0 || k == nfr * n + 1) begin
                    exp_edge = 0; exp_bit = 0; exp_en = 5'b00000;
                end else if (fk == 0) begin
                    exp_edge = 0; exp_bit = n / p; exp_en = 5'b10000;
                end else begin
                    exp_edge = fk % p;
                    exp_bit  = b;
                    exp_en   = {1'b1, b == 0, pen && (b == DW + 1), b == stop_b, 1'b1};
                end
                if (int'(edge_cnt) != exp_edge || int'(bit_cnt) != exp_bit) r_ctr_bad++;
                got_en = {dat_samp_en, strt_chk_en, par_chk_en, stp_chk_en, clearFlag};
                if (got_en !== exp_en) r_en_bad++;
            end
        end
        RST = 1'b0;
    endtask

    initial begin
        int g_deser, g_dv, g_clr;
        RST = 1'b1; RX_IN = 1'b1; PAR_EN = 1'b0; Prescale = 6'd8;
        DONE = 1'b0; strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
        repeat (3) @(negedge CLK);
        #1;
        chk("reset_outputs",
            {edge_cnt, bit_cnt, dat_samp_en, strt_chk_en, par_chk_en,
             stp_chk_en, clearFlag, deser_en, data_valid, frame_err}, 0);
        @(negedge CLK);
        RST = 1'b0;
        repeat (2) @(negedge CLK);

        // good frame, P=8, parity on
        run_seq(8, 1'b1, 8'hA5, 1'b0, 1'b0, 1, -1, -1);
        chk("good_deser_cnt", r_deser, 8);
        chk("good_deser_byte", r_byte, 8'hA5);
        chk("good_dv_cycle", r_dv_first, 88);
        chk("good_dv_cnt", r_dv_cnt, 1);
        chk("good_fe_cnt", r_fe_cnt, 0);
        chk("good_counters", r_ctr_bad, 0);
        chk("good_enables", r_en_bad, 0);

        // parity error with parity on
        run_seq(8, 1'b1, 8'hA5, 1'b1, 1'b0, 1, -1, -1);
        chk("perr_fe_cycle", r_fe_first, 88);
        chk("perr_dv_cnt", r_dv_cnt, 0);

        // parity flag ignored with parity off
        run_seq(8, 1'b0, 8'hA5, 1'b1, 1'b0, 1, -1, -1);
        chk("nopar_dv_cycle", r_dv_first, 80);
        chk("nopar_fe_cnt", r_fe_cnt, 0);
        chk("nopar_enables", r_en_bad, 0);

        // back-to-back, P=16, parity off
        run_seq(16, 1'b0, 8'h3C, 1'b0, 1'b0, 2, -1, -1);
        chk("b2b_dv_cnt", r_dv_cnt, 2);
        chk("b2b_dv_first", r_dv_first, 160);
        chk("b2b_dv_last", r_dv_last, 320);
        chk("b2b_deser_cnt", r_deser, 16);
        chk("b2b_counters", r_ctr_bad, 0);
        chk("b2b_enables", r_en_bad, 0);

        // stop error, P=32
        run_seq(32, 1'b0, 8'h5A, 1'b0, 1'b1, 1, -1, -1);
        chk("serr_fe_cycle", r_fe_first, 320);
        chk("serr_dv_cnt", r_dv_cnt, 0);
        chk("serr_counters", r_ctr_bad, 0);

        // reset during DATA bit 4, then a clean frame
        run_seq(8, 1'b1, 8'hA5, 1'b0, 1'b0, 1, -1, 34);
        chk("rst_dv_cnt", r_dv_cnt, 0);
        chk("rst_fe_cnt", r_fe_cnt, 0);
        chk("rst_deser_cnt", r_deser, 3);
        chk("rst_pre_enables", r_en_bad, 0);
        run_seq(16, 1'b1, 8'h96, 1'b0, 1'b0, 1, -1, -1);
        chk("post_rst_dv_cycle", r_dv_first, 176);
        chk("post_rst_byte", r_byte, 8'h96);

        // PAR_EN and Prescale changed during DATA are ignored
        run_seq(8, 1'b1, 8'hC3, 1'b0, 1'b0, 1, 30, -1);
        chk("cfg_dv_cycle", r_dv_first, 88);
        chk("cfg_counters", r_ctr_bad, 0);
        chk("cfg_enables", r_en_bad, 0);

        // start glitch, P=8, line low for 2 cycles
        PAR_EN = 1'b0; Prescale = 6'd8; par_err = 1'b0; stp_err = 1'b0;
        g_deser = 0; g_dv = 0; g_clr = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            RX_IN       = (k >= 2);
            strt_glitch = (k >= 2) && (k <= 8);
            DONE        = ((k % 8) == 6);
            #1;
            if (k == 7) chk("glitch_e7_start_en", {strt_chk_en, clearFlag}, 3);
            if (k == 8) chk("glitch_c8_idle", {dat_samp_en, clearFlag, edge_cnt}, 0);
            if (deser_en) g_deser++;
            if (data_valid || frame_err) g_dv++;
            if (k >= 8 && clearFlag) g_clr++;
        end
        strt_glitch = 1'b0;
        DONE = 1'b0;
        chk("glitch_deser", g_deser, 0);
        chk("glitch_verdict", g_dv, 0);
        chk("glitch_clear_low", g_clr, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
